// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: bimodal branch predictor with a one-entry resolution tracker.
// A table of 2-bit saturating counters is indexed by pc[IDX_W+1:2]. The decode-stage
// prediction is carried one cycle to execute, where it is compared against the
// resolved direction, and the counter at that index is trained.
// An internal FSM clears the whole table, one entry per cycle.
// Optional feature macro: BP_STATS_EN adds resolution and mispredict counters.
module branch_predict_ctrl #(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_branch_i,
  input  logic [31:0] lookup_pc_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        resolve_i,
  input  logic        taken_i,
  input  logic        clear_i,
  output logic [1:0]  predict_o,
  output logic        mispredict_o,
  output logic        busy_o
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches_o,
  output logic [31:0] stat_mispred_o
`endif
);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(ENTRIES - 1);
  localparam logic [1:0]       CTR_INIT = 2'b01;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [1:0]       ctr_tbl [ENTRIES];

  logic [IDX_W-1:0] idx_p0;
  logic             vld_p1;
  logic             flush_pend;
  logic             pred_taken_p1;
  logic [IDX_W-1:0] idx_p1;
  logic             res_acc;
  logic             clear_entry;
  logic             unused_pc_bits;

  // One step of a 2-bit saturating counter; the end points hold instead of wrapping.
  function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up);
    logic [1:0] nxt;
    nxt = ctr;
    if (up) begin
      if (ctr != 2'b11) nxt = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

  // ---- decode stage (p0): table lookup ----
  assign idx_p0         = lookup_pc_i[IDX_W+1:2];
  assign unused_pc_bits = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0]};

  // Prediction code; a table mid-clear is treated as all weakly not-taken.
  always_comb begin
    predict_o = 2'b00;
    if (is_branch_i) begin
      if (state_q == ST_CLEAR)          predict_o = 2'b01;
      else if (ctr_tbl[idx_p0][1])      predict_o = 2'b10;
      else                              predict_o = 2'b01;
    end
  end

  // ---- execute stage (p1): carried prediction ----
  // Tracker valid plus a pending flush that was shadowed by a stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1     <= 1'b0;
      flush_pend <= 1'b0;
    end else if (stall_i) begin
      if (flush_i) flush_pend <= 1'b1;
    end else begin
      flush_pend <= 1'b0;
      if (flush_i || flush_pend) vld_p1 <= 1'b0;
      else                       vld_p1 <= is_branch_i;
    end
  end

  // Tracker payload; only meaningful while vld_p1 is set.
  always_ff @(posedge clk) begin
    if (!stall_i) begin
      pred_taken_p1 <= predict_o[1];
      idx_p1        <= idx_p0;
    end
  end

  assign res_acc = resolve_i && vld_p1;

  // Mispredict pulse, registered so it appears the cycle after resolution.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mispredict_o <= 1'b0;
    else      mispredict_o <= res_acc && (taken_i != pred_taken_p1);
  end

  // Counter table: clear sweep has priority; training is dropped while clearing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_tbl[i] <= CTR_INIT;
    end else if (state_q == ST_CLEAR) begin
      ctr_tbl[ptr_q] <= CTR_INIT;
    end else if (res_acc) begin
      ctr_tbl[idx_p1] <= sat_step(ctr_tbl[idx_p1], taken_i);
    end
  end

  // Clear FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Clear FSM next state and busy flag; clear_i is ignored once clearing.
  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_i) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy_o = 1'b1;
        if (ptr_q == PTR_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign clear_entry = (state_q == ST_IDLE) && (state_d == ST_CLEAR);

  // Clear sweep pointer; parked at zero while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      ptr_q <= '0;
    else if (state_q == ST_CLEAR)  ptr_q <= ptr_q + IDX_W'(1);
    else                           ptr_q <= '0;
  end

`ifdef BP_STATS_EN
  // Statistics: accepted resolutions and mispredict pulses, zeroed on clear entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches_o <= 32'd0;
      stat_mispred_o  <= 32'd0;
    end else if (clear_entry) begin
      stat_branches_o <= 32'd0;
      stat_mispred_o  <= 32'd0;
    end else begin
      if (res_acc)      stat_branches_o <= stat_branches_o + 32'd1;
      if (mispredict_o) stat_mispred_o  <= stat_mispred_o + 32'd1;
    end
  end
`endif

endmodule
